// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, the canonical NOP and the PC increment.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  // addi x0, x0, 0 -- used to fill squashed IF/ID slots
  localparam instr_t NOP_INSTR = 32'h00000013;
  localparam addr_t  PC_STEP   = 64'd4;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: the fetch stage drives the address and the
// asynchronous memory returns the instruction word in the same cycle.
interface if_fetch_stage_if;
  import riscv_pkg::*;

  addr_t  imem_addr;
  instr_t imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A flush squashes the slot to a NOP bubble and
// takes precedence over a load; with neither asserted the slot holds.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  addr_t  pc_in,
  input  instr_t instr_in,
  output addr_t  pc,
  output instr_t instr,
  output logic   valid
);

  // Capture, squash or hold the fetched instruction slot
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and feeds the IF/ID register. Redirects beat stalls; a redirect
// target with non-zero low bits is force-aligned and flagged for one cycle.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  addr_t                   branch_target,
  if_fetch_stage_if.master        imem,
  output addr_t                   if_id_pc,
  output instr_t                  if_id_instr,
  output logic                    if_id_valid,
  output logic                    fetch_misaligned,
  output logic [31:0]             fetch_count
);

  addr_t       pc_q;
  logic        fetch_misaligned_q;
  logic [31:0] fetch_count_q;
  logic        load;

  assign imem.imem_addr = pc_q;
  assign load           = !stall && !branch_taken;

  // PC select, misalignment pulse and fetched-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q               <= RESET_PC;
      fetch_misaligned_q <= 1'b0;
      fetch_count_q      <= '0;
    end else if (branch_taken) begin
      pc_q               <= {branch_target[XLEN-1:2], 2'b00};
      fetch_misaligned_q <= |branch_target[1:0];
    end else if (stall) begin
      fetch_misaligned_q <= 1'b0;
    end else begin
      pc_q               <= pc_q + PC_STEP;
      fetch_count_q      <= fetch_count_q + 32'd1;
      fetch_misaligned_q <= 1'b0;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .flush    (branch_taken),
    .pc_in    (pc_q),
    .instr_in (imem.imem_instr),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

  assign fetch_misaligned = fetch_misaligned_q;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a four-word asynchronous instruction memory.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid, fetch_misaligned;
  logic [31:0] fetch_count;
  int          total = 0;
  int          bad = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem             (bus),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid),
    .fetch_misaligned (fetch_misaligned),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  // Default memory image; unmapped addresses return a NOP
  always_comb begin
    case (bus.imem_addr)
      64'h0:   bus.imem_instr = 32'h02853483;
      64'h4:   bus.imem_instr = 32'h009A84B3;
      64'h8:   bus.imem_instr = 32'h00148493;
      64'hC:   bus.imem_instr = 32'h02953423;
      default: bus.imem_instr = 32'h00000013;
    endcase
  end

  // One clock edge, then settle and log the transaction
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    $display("%s: addr=%h ifid_pc=%h instr=%h v=%0b mis=%0b cnt=%0d",
             tag, bus.imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_misaligned, fetch_count);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < cycles; i++) step("reset");
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2);
    total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
    total++; if (if_id_pc !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_id_pc); end
    total++; if (if_id_instr !== 32'h00000013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", if_id_instr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", fetch_misaligned); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h02853483; exp_instr[1] = 32'h009A84B3;
    exp_instr[2] = 32'h00148493; exp_instr[3] = 32'h02953423;
    for (int i = 0; i < 4; i++) begin
      step("fetch");
      total++; if (if_id_instr !== exp_instr[i]) begin bad++; $display("FAIL seq_instr%0d got=%h exp=%h", i, if_id_instr, exp_instr[i]); end
      total++; if (if_id_pc !== 64'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, if_id_pc, 64'(4 * i)); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b exp=1", i, if_id_valid); end
      total++; if (bus.imem_addr !== 64'(4 * i + 4)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.imem_addr, 64'(4 * i + 4)); end
    end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_cnt got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_stall;
    do_reset(1);
    step("fetch");
    step("fetch");
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("stall");
      total++; if (bus.imem_addr !== 64'h8) begin bad++; $display("FAIL stall_addr%0d got=%h exp=8", i, bus.imem_addr); end
      total++; if (if_id_pc !== 64'h4) begin bad++; $display("FAIL stall_pc%0d got=%h exp=4", i, if_id_pc); end
      total++; if (if_id_instr !== 32'h009A84B3) begin bad++; $display("FAIL stall_instr%0d got=%h exp=009a84b3", i, if_id_instr); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_cnt%0d got=%0d exp=2", i, fetch_count); end
    end
    stall = 1'b0;
    step("fetch");
    total++; if (if_id_instr !== 32'h00148493) begin bad++; $display("FAIL unstall_instr got=%h exp=00148493", if_id_instr); end
    total++; if (if_id_pc !== 64'h8) begin bad++; $display("FAIL unstall_pc got=%h exp=8", if_id_pc); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL unstall_cnt got=%0d exp=3", fetch_count); end
    total++; if (bus.imem_addr !== 64'hC) begin bad++; $display("FAIL unstall_addr got=%h exp=c", bus.imem_addr); end
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 64'h0;
    step("branch");
    branch_taken = 1'b0;
    total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL br_addr got=%h exp=0", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_instr !== 32'h00000013) begin bad++; $display("FAIL br_instr got=%h exp=00000013", if_id_instr); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL br_cnt got=%0d exp=3", fetch_count); end
    step("fetch");
    total++; if (if_id_instr !== 32'h02853483) begin bad++; $display("FAIL br_tgt_instr got=%h exp=02853483", if_id_instr); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL br_tgt_valid got=%b exp=1", if_id_valid); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL br_tgt_cnt got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_branch_over_stall;
    branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h8;
    step("br+stall");
    branch_taken = 1'b0; stall = 1'b0;
    total++; if (bus.imem_addr !== 64'h8) begin bad++; $display("FAIL bs_addr got=%h exp=8", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL bs_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_instr !== 32'h00000013) begin bad++; $display("FAIL bs_instr got=%h exp=00000013", if_id_instr); end
    step("fetch");
    total++; if (if_id_instr !== 32'h00148493) begin bad++; $display("FAIL bs_next got=%h exp=00148493", if_id_instr); end
  endtask

  task automatic test_misaligned;
    branch_taken = 1'b1; branch_target = 64'h6;
    step("br_mis");
    branch_taken = 1'b0;
    total++; if (bus.imem_addr !== 64'h4) begin bad++; $display("FAIL mis_addr got=%h exp=4", bus.imem_addr); end
    total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", fetch_misaligned); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", if_id_valid); end
    step("fetch");
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", fetch_misaligned); end
    total++; if (if_id_instr !== 32'h009A84B3) begin bad++; $display("FAIL mis_next got=%h exp=009a84b3", if_id_instr); end
    total++; if (if_id_pc !== 64'h4) begin bad++; $display("FAIL mis_next_pc got=%h exp=4", if_id_pc); end
  endtask

  task automatic test_reset_override;
    do_reset(1);
    for (int i = 0; i < 3; i++) step("fetch");
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL ro_pre_cnt got=%0d exp=3", fetch_count); end
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h7;
    step("rst+all");
    total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL ro_addr got=%h exp=0", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL ro_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_pc !== 64'h0) begin bad++; $display("FAIL ro_pc got=%h exp=0", if_id_pc); end
    total++; if (if_id_instr !== 32'h00000013) begin bad++; $display("FAIL ro_instr got=%h exp=00000013", if_id_instr); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL ro_mis got=%b exp=0", fetch_misaligned); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL ro_cnt got=%0d exp=0", fetch_count); end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_misaligned();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program counter, drives the address port of the combinational instruction memory, and selects the next PC from sequential (+4) or branch redirect. It captures the returned instruction into the IF/ID pipeline register consumed by decode. It also handles stall hold, branch flush with NOP bubble insertion, and alignment correction.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard-unit hold; freezes PC and IF/ID
- branch_taken  in  1  redirect request from EX/MEM
- branch_target  in  64  redirect address
- imem_addr  out  64  instruction memory address (Inst_Address)
- imem_instr  in  32  instruction memory data (Instruction)
- if_id_pc  out  64  PC of the instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_misaligned  out  1  one-cycle pulse: a redirect target had bits [1:0] ≠ 0
- fetch_count  out  32  count of valid instructions loaded into IF/ID

## Operation
- One clock, clk. Reset is synchronous and active-high on reset.
- State: pc_q, the IF/ID register (pc, instr, valid), fetch_misaligned_q, fetch_count_q.
- imem_addr = pc_q, combinational. Instruction memory reads asynchronously, so imem_instr is valid in the same cycle.
- Per-edge priority is reset > branch_taken > stall > normal.
  - reset: pc_q ← RESET_PC; if_id_pc ← 0; if_id_instr ← NOP (32'h00000013); if_id_valid ← 0; fetch_misaligned ← 0; fetch_count ← 0.
  - branch_taken: pc_q ← {branch_target[63:2], 2'b00}; IF/ID ← bubble (pc 0, instr NOP, valid 0); fetch_misaligned ← |branch_target[1:0]. Branch_taken overrides a simultaneous stall.
  - stall (no branch): pc_q, IF/ID and fetch_count hold; fetch_misaligned ← 0.
  - normal: if_id_pc ← pc_q; if_id_instr ← imem_instr; if_id_valid ← 1; pc_q ← pc_q + 4; fetch_count ← fetch_count + 1; fetch_misaligned ← 0.
- Arithmetic:
  - PC adds are 64-bit modulo 2^64, with no overflow detection.
  - fetch_count wraps modulo 2^32.
- No compressed instructions. PC is always 4-byte aligned, so pc_q[1:0] is always 0.

## Timing
- Fetch latency: one cycle. An instruction at address A appears on if_id_instr on the edge after imem_addr = A.
- First edge after reset release loads the instruction at RESET_PC into IF/ID with valid = 1.
- Branch penalty as seen at IF/ID:
  - one bubble cycle (valid 0) on the edge that applies the redirect;
  - target instruction valid on the following edge.
- Stall of N cycles leaves IF/ID and imem_addr unchanged for exactly N edges.
- Reset asserted mid-stall or mid-redirect discards all in-flight state on that edge.
- All outputs are registered except imem_addr, which is a direct copy of pc_q.

## Structure
- Shared package riscv_pkg: XLEN = 64, ILEN = 32, NOP_INSTR = 32'h00000013, PC_STEP = 4.
- One sub-module, if_id_reg: holds the IF/ID pipeline register.
  - inputs: load, flush, pc, instr;
  - outputs: pc, instr, valid.
- PC register, next-PC mux, misalignment flag and counter stay in the top.

## Test plan
Instruction memory uses its default image: word 0x0 = 0x02853483, 0x4 = 0x009A84B3, 0x8 = 0x00148493, 0xC = 0x02953423.
- Reset 2 cycles, then release. Required:
  - edge 1: if_id_pc = 0x0, if_id_instr = 0x02853483, valid = 1, imem_addr = 0x4;
  - edges 2–4: 0x009A84B3, 0x00148493, 0x02953423 in order;
  - fetch_count = 4.
- Stall for 2 cycles while imem_addr = 0x8. Required: imem_addr stays 0x8; IF/ID holds pc 0x4 / 0x009A84B3; fetch_count unchanged. After release, the next edge loads 0x00148493.
- branch_taken with target 0x0 while pc = 0xC. Required:
  - next edge: imem_addr = 0x0, if_id_valid = 0, if_id_instr = 0x00000013;
  - following edge: if_id_instr = 0x02853483, valid = 1.
- branch_taken and stall asserted together, target 0x8. Required: branch wins; imem_addr = 0x8; bubble in IF/ID.
- branch_target = 0x6. Required: imem_addr = 0x4; fetch_misaligned = 1 for exactly one cycle; next valid instruction is 0x009A84B3.
- reset asserted together with stall and branch_taken after 3 fetches. Required: all outputs return to reset values on that edge; imem_addr = RESET_PC.
